// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: fetch owns the single-port RAM by default, the
// program loader gets bounded write bursts, and every loader tenure ends in a flush.
module imem_arbiter #(
  parameter int AW        = 6,
  parameter int DW        = 32,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          FetchReq,
  input  logic [AW-1:0] FetchAddr,
  output logic          FetchGnt,
  output logic [DW-1:0] FetchData,
  input  logic          LdReq,
  input  logic          LdValid,
  input  logic [AW-1:0] LdAddr,
  input  logic [DW-1:0] LdData,
  input  logic          LdLast,
  output logic          LdReady,
  output logic          LdDone,
  output logic [AW-1:0] MemAddr,
  output logic          MemWe,
  output logic [DW-1:0] MemWdata,
  input  logic [DW-1:0] MemRdata,
  output logic          ImemHold,
  output logic          ImemFlush
);

  localparam int CW = $clog2(MAX_BURST) + 1;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    SWITCH = 2'd1,
    LOAD   = 2'd2,
    FLUSH  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_seen_q, last_seen_d;
  logic            cool_q, cool_d;

  // The RAM read port is combinational, so read data simply passes through.
  assign FetchData = MemRdata;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_seen_d = last_seen_q;
    cool_d      = cool_q;
    FetchGnt    = 1'b0;
    LdReady     = 1'b0;
    LdDone      = 1'b0;
    MemAddr     = FetchAddr;
    MemWe       = 1'b0;
    MemWdata    = '0;
    ImemHold    = 1'b0;
    ImemFlush   = 1'b0;

    unique case (state_q)
      FETCH: begin
        FetchGnt = FetchReq;
        cool_d   = 1'b0;
        // Cool blocks re-arbitration for one fetch cycle after each tenure.
        if (LdReq && !cool_q) state_d = SWITCH;
      end
      SWITCH: begin
        ImemHold = 1'b1;
        state_d  = LOAD;
      end
      LOAD: begin
        ImemHold = 1'b1;
        LdReady  = 1'b1;
        MemAddr  = LdAddr;
        MemWdata = LdData;
        MemWe    = LdValid;
        if (LdValid) begin
          cnt_d = cnt_q + CW'(1);
          if (LdLast) begin
            last_seen_d = 1'b1;
            state_d     = FLUSH;
          end else if (cnt_q + CW'(1) == CW'(MAX_BURST)) begin
            state_d = FLUSH;
          end
        end else if (!LdReq) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        ImemHold    = 1'b1;
        ImemFlush   = 1'b1;
        LdDone      = last_seen_q;
        cnt_d       = '0;
        last_seen_d = 1'b0;
        cool_d      = 1'b1;
        state_d     = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= FETCH;
      cnt_q       <= '0;
      last_seen_q <= 1'b0;
      cool_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_seen_q <= last_seen_d;
      cool_q      <= cool_d;
    end
  end

endmodule
